// File: rtl/moving_average_v4.sv
// Moving-average / weighted smoothing filter over a 16-deep unsigned sample history.
// A sample shifts in on the accepting edge; the result is published on the following edge.
module moving_average_v4 #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          data_refresh,
    input  logic          output_refresh_mode,
    input  logic [DW-1:0] din,
    input  logic [2:0]    mode,
    output logic [DW-1:0] dout,
    output logic          output_pulse
);

    localparam int unsigned AW = DW + 4;
    localparam int unsigned CW = 5;

    logic [DW-1:0] hist_q [DEPTH];
    logic [DW-1:0] dout_q, dout_d;
    logic          pulse_q;
    logic          pend_q, pend_d;
    logic [2:0]    pend_mode_q, pend_mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q;
    logic          orm_q;

    logic          accept;
    logic [CW-1:0] win;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] s2, s3w, s4, s8, s16;
    logic [DW-1:0] result;

    assign accept = enable & data_refresh;

    // Window length per filter mode
    always_comb begin
        win = CW'(1);
        case (mode)
            3'd1:    win = CW'(2);
            3'd2:    win = CW'(3);
            3'd3:    win = CW'(4);
            3'd4:    win = CW'(8);
            3'd5:    win = CW'(16);
            default: win = CW'(1);
        endcase
    end

    // Window counter and publish decision, taken on the accepting edge
    always_comb begin
        cnt_base    = ((mode != mode_q) || (output_refresh_mode != orm_q)) ? '0 : cnt_q;
        cnt_inc     = cnt_base + CW'(1);
        cnt_d       = cnt_base;
        pend_d      = 1'b0;
        pend_mode_d = pend_mode_q;
        if (accept) begin
            pend_mode_d = mode;
            if (output_refresh_mode || (cnt_inc >= win)) begin
                pend_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    // Partial sums over the already-shifted history
    always_comb begin
        s16 = '0;
        s8  = '0;
        s4  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s16 = s16 + AW'(hist_q[i]);
            if (i < 8) s8 = s8 + AW'(hist_q[i]);
            if (i < 4) s4 = s4 + AW'(hist_q[i]);
        end
        s2  = AW'(hist_q[0]) + AW'(hist_q[1]);
        s3w = (AW'(hist_q[0]) << 1) + AW'(hist_q[1]) + AW'(hist_q[2]);
    end

    always_comb begin
        case (pend_mode_q)
            3'd1:    result = DW'(s2 >> 1);
            3'd2:    result = DW'(s3w >> 2);
            3'd3:    result = DW'(s4 >> 2);
            3'd4:    result = DW'(s8 >> 3);
            3'd5:    result = DW'(s16 >> 4);
            default: result = hist_q[0];
        endcase
        dout_d = pend_q ? result : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            dout_q      <= '0;
            pulse_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_mode_q <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            orm_q       <= 1'b0;
        end else begin
            if (accept) begin
                hist_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
            end
            dout_q      <= dout_d;
            pulse_q     <= pend_q;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode;
            orm_q       <= output_refresh_mode;
        end
    end

    assign dout         = dout_q;
    assign output_pulse = pulse_q;

endmodule

// File: tb/tb_moving_average_v4.sv
// Directed testbench for moving_average_v4 with hand-computed expected results.
module tb_moving_average_v4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        data_refresh;
    logic        output_refresh_mode;
    logic [15:0] din;
    logic [2:0]  mode;
    logic [15:0] dout;
    logic        output_pulse;

    int cmp_cnt = 0;
    int err_cnt = 0;

    moving_average_v4 dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .data_refresh        (data_refresh),
        .output_refresh_mode (output_refresh_mode),
        .din                 (din),
        .mode                (mode),
        .dout                (dout),
        .output_pulse        (output_pulse)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [2:0] m, input logic orm);
        rst_n               = 1'b0;
        enable              = 1'b1;
        data_refresh        = 1'b0;
        din                 = '0;
        mode                = m;
        output_refresh_mode = orm;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated strobe; returns pulse after the accepting edge and dout/pulse after the next edge
    task automatic strobe(input logic [15:0] d, output logic [15:0] od, output logic op,
                          output logic op_early);
        @(negedge clk);
        data_refresh = 1'b1;
        din          = d;
        @(posedge clk);
        #1;
        data_refresh = 1'b0;
        op_early     = output_pulse;
        @(posedge clk);
        #1;
        od = dout;
        op = output_pulse;
    endtask

    task automatic test_reset();
        do_reset(3'd0, 1'b1);
        cmp_cnt++;
        if (dout !== 16'd0 || output_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: dout=%0d pulse=%0b, need dout=0 pulse=0", dout, output_pulse);
        end
    endtask

    task automatic test_pass_through();
        logic [15:0] od;
        logic        op, ope;
        do_reset(3'd0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            strobe(16'(i), od, op, ope);
            cmp_cnt++;
            if (od !== 16'(i) || op !== 1'b1 || ope !== 1'b0) begin
                err_cnt++;
                $display("FAIL mode0_s%0d: dout=%0d pulse=%0b early=%0b, need %0d/1/0", i, od, op, ope, i);
            end
        end
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (output_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL mode0_pulse_width: pulse=%0b, need 0", output_pulse);
        end
    endtask

    task automatic test_mode1_mode2();
        logic [15:0] od;
        logic        op, ope;
        logic [15:0] exp1 [3] = '{16'd0, 16'd1, 16'd2};
        logic [15:0] in2  [3] = '{16'd4, 16'd8, 16'd12};
        logic [15:0] exp2 [3] = '{16'd2, 16'd5, 16'd9};
        do_reset(3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            strobe(16'(i + 1), od, op, ope);
            cmp_cnt++;
            if (od !== exp1[i] || op !== 1'b1) begin
                err_cnt++;
                $display("FAIL mode1_s%0d: dout=%0d pulse=%0b, need %0d/1", i, od, op, exp1[i]);
            end
        end
        do_reset(3'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            strobe(in2[i], od, op, ope);
            cmp_cnt++;
            if (od !== exp2[i] || op !== 1'b1) begin
                err_cnt++;
                $display("FAIL mode2_s%0d: dout=%0d pulse=%0b, need %0d/1", i, od, op, exp2[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp3 [10] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        do_reset(3'd3, 1'b1);
        data_refresh = 1'b1;
        din          = 16'd1;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (i < 10) din = 16'(i + 1);
            else        data_refresh = 1'b0;
            if (i >= 2) begin
                cmp_cnt++;
                if (dout !== exp3[i-2] || output_pulse !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL b2b_mode3_s%0d: dout=%0d pulse=%0b, need %0d/1", i - 1, dout, output_pulse, exp3[i-2]);
                end
            end
        end
    endtask

    task automatic test_full_window();
        logic [15:0] od;
        logic        op, ope;
        do_reset(3'd5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            strobe(16'd100, od, op, ope);
            if (i == 0) begin
                cmp_cnt++;
                if (od !== 16'd6) begin
                    err_cnt++;
                    $display("FAIL mode5_first: dout=%0d, need 6", od);
                end
            end
        end
        cmp_cnt++;
        if (od !== 16'd100) begin
            err_cnt++;
            $display("FAIL mode5_100: dout=%0d, need 100", od);
        end
        for (int i = 0; i < 16; i++) begin
            strobe(16'hFFFF, od, op, ope);
            if (i == 0) begin
                cmp_cnt++;
                if (od !== 16'd4189) begin
                    err_cnt++;
                    $display("FAIL mode5_mix: dout=%0d, need 4189", od);
                end
            end
        end
        cmp_cnt++;
        if (od !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL mode5_max: dout=%0d, need 65535", od);
        end
    endtask

    task automatic test_decimated();
        logic [15:0] od;
        logic        op, ope;
        logic [15:0] expd [8] = '{16'd0, 16'd0, 16'd0, 16'd2, 16'd2, 16'd2, 16'd2, 16'd6};
        do_reset(3'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            strobe(16'(i + 1), od, op, ope);
            cmp_cnt++;
            if (od !== expd[i] || op !== ((i == 3) || (i == 7))) begin
                err_cnt++;
                $display("FAIL decim_s%0d: dout=%0d pulse=%0b, need %0d/%0b", i + 1, od, op, expd[i],
                         (i == 3) || (i == 7));
            end
        end
    endtask

    task automatic test_enable_hold();
        // Continues from the decimated scenario with dout=6
        @(negedge clk);
        enable       = 1'b0;
        data_refresh = 1'b1;
        din          = 16'd100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) data_refresh = 1'b0;
            cmp_cnt++;
            if (dout !== 16'd6 || output_pulse !== 1'b0) begin
                err_cnt++;
                $display("FAIL enable_hold_c%0d: dout=%0d pulse=%0b, need 6/0", i, dout, output_pulse);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] od;
        logic        op, ope;
        do_reset(3'd0, 1'b1);
        strobe(16'd500, od, op, ope);
        cmp_cnt++;
        if (od !== 16'd500) begin
            err_cnt++;
            $display("FAIL rst_mid_pre: dout=%0d, need 500", od);
        end
        @(negedge clk);
        data_refresh = 1'b1;
        din          = 16'd7;
        @(posedge clk);
        #1;
        data_refresh = 1'b0;
        rst_n        = 1'b0;
        #1;
        cmp_cnt++;
        if (dout !== 16'd0 || output_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_async: dout=%0d pulse=%0b, need 0/0", dout, output_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (dout !== 16'd0 || output_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_discard: dout=%0d pulse=%0b, need 0/0", dout, output_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_mode1_mode2();
        test_back_to_back();
        test_full_window();
        test_decimated();
        test_enable_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
